// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_arb_pkg
// Description : Shared types and the round-robin pick helper used by the
//               frame arbiter (and reusable by other arbiters).
// Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

  // Largest channel count the pick helper handles.
  localparam int MAX_CH   = 32;
  localparam int MAX_W_CH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    PAD  = 2'd2
  } state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_W_CH-1:0] idx;
  } pick_t;

  // Round-robin pick: first set bit of req strictly after 'last', scanning
  // (last+1) mod ch upward. Equivalent to rotate / priority-encode / un-rotate.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                    input int ch,
                                    input int last);
    pick_t res;
    int    idx;
    res = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      idx = last + k;
      if (idx >= ch) idx = idx - ch;
      if ((k <= ch) && !res.found && req[idx[MAX_W_CH-1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[MAX_W_CH-1:0];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_arbiter
// Description : Frame-granular round-robin arbiter feeding one width
//               converter from CH sources. Forwards whole frames, drops
//               orphan words, pads truncated frames, flags both per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int CH          = 4,
  parameter  int N           = 8,
  parameter  int FRAME_WORDS = 3,
  localparam int W_CH        = (CH > 1) ? $clog2(CH) : 1,
  localparam int W_FW        = $clog2(FRAME_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,            // asynchronous, active-low
  input  logic [CH-1:0]     s_axis_tvalid,
  input  logic [CH*N-1:0]   s_axis_tdata,
  input  logic [CH-1:0]     s_axis_tfirst,
  output logic [CH-1:0]     s_axis_tnext,
  output logic              m_axis_tvalid,
  output logic [N-1:0]      m_axis_tdata,
  output logic              m_axis_tfirst,
  input  logic              m_axis_tnext,
  output logic [W_CH-1:0]   m_axis_tid,
  input  logic              err_clr,
  output logic [CH-1:0]     err,
  output logic [15:0]       frame_count
);

  typedef struct packed {
    state_t          state;
    logic [W_CH-1:0] grant;
    logic [W_CH-1:0] rr_last;
    logic [W_FW-1:0] cnt;
    logic [CH-1:0]   err;
    logic [15:0]     frame_count;
  } arb_reg_t;

  arb_reg_t        reg_q, reg_d;
  logic [CH-1:0]   w_cand;
  pick_t           w_pick;
  logic            w_pick_ok;
  logic            w_g_vld, w_g_fst;
  logic [N-1:0]    w_g_dat;
  logic            w_last;
  logic            w_word_done;
  logic            w_rearb;
  logic [CH-1:0]   w_set_err;

  // A channel may start a frame only when it presents a valid tfirst word.
  assign w_cand    = s_axis_tvalid & s_axis_tfirst;
  assign w_pick    = rr_pick(MAX_CH'(w_cand), CH, int'(reg_q.rr_last));
  assign w_pick_ok = w_pick.found && (int'(w_pick.idx) < CH);
  assign w_last    = (reg_q.cnt == W_FW'(FRAME_WORDS - 1));

  // Mux the granted channel's word.
  always_comb begin
    w_g_vld = 1'b0;
    w_g_fst = 1'b0;
    w_g_dat = '0;
    for (int i = 0; i < CH; i++) begin
      if (W_CH'(i) == reg_q.grant) begin
        w_g_vld = s_axis_tvalid[i];
        w_g_fst = s_axis_tfirst[i];
        w_g_dat = s_axis_tdata[i*N +: N];
      end
    end
  end

  // Next-state, output drive, orphan discard and arbitration.
  always_comb begin
    reg_d         = reg_q;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tfirst = 1'b0;
    s_axis_tnext  = '0;
    w_set_err     = '0;
    w_word_done   = 1'b0;
    w_rearb       = 1'b0;

    case (reg_q.state)
      IDLE: w_rearb = 1'b1;
      PASS: begin
        if (w_g_vld && w_g_fst && (reg_q.cnt != '0)) begin
          // A new frame started before this one finished: hold the word
          // and fill the rest of the frame instead.
          reg_d.state            = PAD;
          w_set_err[reg_q.grant] = 1'b1;
        end else begin
          m_axis_tvalid = w_g_vld;
          m_axis_tdata  = w_g_dat;
          m_axis_tfirst = w_g_fst;
          if (w_g_vld && m_axis_tnext) begin
            s_axis_tnext[reg_q.grant] = 1'b1;
            w_word_done               = 1'b1;
          end
        end
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        w_word_done   = m_axis_tnext;
      end
      default: reg_d.state = IDLE;
    endcase

    if (w_word_done) begin
      if (w_last) begin
        reg_d.frame_count = reg_q.frame_count + 16'd1;
        w_rearb           = 1'b1;
      end else begin
        reg_d.cnt = reg_q.cnt + W_FW'(1);
      end
    end

    // Words without tfirst on channels not holding the grant are dropped.
    for (int i = 0; i < CH; i++) begin
      if (((reg_q.state == IDLE) || (W_CH'(i) != reg_q.grant)) &&
          s_axis_tvalid[i] && !s_axis_tfirst[i]) begin
        s_axis_tnext[i] = 1'b1;
        w_set_err[i]    = 1'b1;
      end
    end

    if (w_rearb) begin
      if (w_pick_ok) begin
        reg_d.state   = PASS;
        reg_d.grant   = W_CH'(w_pick.idx);
        reg_d.rr_last = W_CH'(w_pick.idx);
        reg_d.cnt     = '0;
      end else begin
        reg_d.state = IDLE;
      end
    end

    // A set event in the same cycle wins over the clear.
    reg_d.err = (reg_q.err & ~{CH{err_clr}}) | w_set_err;

    // No word is consumed while reset is held.
    if (!rst) s_axis_tnext = '0;
  end

  // State register with asynchronous reset; channel 0 gets first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q <= '{state: IDLE, grant: '0, rr_last: W_CH'(CH - 1),
                 cnt: '0, err: '0, frame_count: '0};
    end else begin
      reg_q <= reg_d;
    end
  end

  assign m_axis_tid  = reg_q.grant;
  assign err         = reg_q.err;
  assign frame_count = reg_q.frame_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_arbiter
// Description : Self-checking bench for axis_frame_arbiter: directed frame
//               scenarios plus randomized traffic against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_arbiter;

  localparam int CH = 4;
  localparam int N  = 8;
  localparam int FW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [CH-1:0]     s_tvalid = '0;
  logic [CH*N-1:0]   s_tdata  = '0;
  logic [CH-1:0]     s_tfirst = '0;
  logic [CH-1:0]     s_tnext;
  logic              m_tvalid, m_tfirst;
  logic [N-1:0]      m_tdata;
  logic              m_tnext = 1'b1;
  logic [1:0]        m_tid;
  logic              err_clr = 1'b0;
  logic [CH-1:0]     err;
  logic [15:0]       fc;

  axis_frame_arbiter #(.CH(CH), .N(N), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tfirst(s_tfirst),
    .s_axis_tnext(s_tnext),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tfirst(m_tfirst),
    .m_axis_tnext(m_tnext), .m_axis_tid(m_tid),
    .err_clr(err_clr), .err(err), .frame_count(fc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Source queues: {tfirst, data}; pres = head word currently offered.
  logic [8:0]  srcq [CH][$];
  bit          pres [CH];
  bit          took [CH];
  int          vld_pct   = 100;
  bit          auto_fill = 0;
  int          rdy_mode  = 0;   // 0: always ready, 1: random, 2: manual

  // Observed output transfers: {tid, first, data} and the cycle they happened.
  logic [10:0] logq[$];
  int          logcyc[$];

  // Frame-level reference: mode 0 idle / 1 forwarding / 2 filling.
  int            m_mode, m_grant, m_last, m_cnt;
  logic [CH-1:0] m_err;
  logic [15:0]   m_fc;
  int            n_mode, n_grant, n_last, n_cnt;
  logic [CH-1:0] n_err;
  logic [15:0]   n_fc;
  bit            have_next = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input int i);
    int r;
    int len;
    r = $urandom_range(15);
    if (r == 0) begin
      srcq[i].push_back({1'b0, 8'($urandom)});
    end else begin
      len = (r <= 2) ? $urandom_range(FW - 1, 1) : FW;
      for (int j = 0; j < len; j++) srcq[i].push_back({(j == 0), 8'($urandom)});
    end
  endtask

  // Sources: hold the offered word until the arbiter consumes it.
  task automatic driver_loop();
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < CH; i++) begin
        if (!rst) begin
          pres[i] = 0;
        end else begin
          if (pres[i] && took[i]) begin
            void'(srcq[i].pop_front());
            pres[i] = 0;
          end
          if (auto_fill && srcq[i].size() == 0) push_burst(i);
          if (!pres[i] && srcq[i].size() != 0 && ($urandom_range(99) < vld_pct)) pres[i] = 1;
        end
        s_tvalid[i]       = pres[i];
        s_tfirst[i]       = pres[i] ? srcq[i][0][8] : 1'b0;
        s_tdata[i*N +: N] = pres[i] ? srcq[i][0][7:0] : 8'h00;
      end
      if (rdy_mode == 0)      m_tnext = 1'b1;
      else if (rdy_mode == 1) m_tnext = ($urandom_range(99) < 70);
    end
  endtask

  // Model state advances on the clock edge; reset returns it to power-up.
  task automatic model_update_loop();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_mode = 0; m_grant = 0; m_last = CH - 1; m_cnt = 0; m_err = '0; m_fc = '0;
      end else if (have_next) begin
        m_mode = n_mode; m_grant = n_grant; m_last = n_last; m_cnt = n_cnt;
        m_err = n_err; m_fc = n_fc;
      end
    end
  endtask

  // Each cycle: derive expected outputs from the rules and compare the DUT.
  task automatic compare_loop();
    logic [CH-1:0] etn, set;
    logic          etv, etf;
    logic [7:0]    etd;
    bit            rearb, done;
    int            win, j;
    forever begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) took[i] = rst && s_tnext[i];
      if (!rst) begin
        have_next = 0;
      end else begin
        if (m_tvalid && m_tnext) begin
          logq.push_back({m_tid, m_tfirst, m_tdata});
          logcyc.push_back(cyc);
        end
        etn = '0; set = '0; etv = 0; etf = 0; etd = '0; rearb = 0; done = 0; win = -1;
        n_mode = m_mode; n_grant = m_grant; n_last = m_last; n_cnt = m_cnt; n_fc = m_fc;
        if (m_mode == 0) begin
          rearb = 1;
        end else if (m_mode == 1) begin
          if (s_tvalid[m_grant] && s_tfirst[m_grant] && m_cnt != 0) begin
            n_mode = 2;
            set[m_grant] = 1'b1;
          end else begin
            etv = s_tvalid[m_grant];
            etf = s_tfirst[m_grant];
            etd = s_tdata[m_grant*N +: N];
            if (etv && m_tnext) begin
              etn[m_grant] = 1'b1;
              done = 1;
            end
          end
        end else begin
          etv  = 1'b1;
          done = m_tnext;
        end
        if (done) begin
          if (m_cnt == FW - 1) begin
            n_fc = m_fc + 16'd1;
            rearb = 1;
          end else begin
            n_cnt = m_cnt + 1;
          end
        end
        for (int i = 0; i < CH; i++)
          if ((m_mode == 0 || i != m_grant) && s_tvalid[i] && !s_tfirst[i]) begin
            etn[i] = 1'b1;
            set[i] = 1'b1;
          end
        if (rearb) begin
          for (int k = 1; k <= CH; k++) begin
            j = (m_last + k) % CH;
            if (win < 0 && s_tvalid[j] && s_tfirst[j]) win = j;
          end
          if (win >= 0) begin
            n_mode = 1; n_grant = win; n_last = win; n_cnt = 0;
          end else begin
            n_mode = 0;
          end
        end
        n_err = (err_clr ? '0 : m_err) | set;
        have_next = 1;

        chk("m_axis_tvalid", 32'(m_tvalid), 32'(etv));
        chk("s_axis_tnext", 32'(s_tnext), 32'(etn));
        chk("m_axis_tid", 32'(m_tid), 32'(m_grant));
        chk("err", 32'(err), 32'(m_err));
        chk("frame_count", 32'(fc), 32'(m_fc));
        if (etv) begin
          chk("m_axis_tdata", 32'(m_tdata), 32'(etd));
          chk("m_axis_tfirst", 32'(m_tfirst), 32'(etf));
        end
      end
    end
  endtask

  task automatic reset_begin();
    rst     = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < CH; i++) srcq[i].delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_end();
    @(posedge clk);
    #2;
    logq.delete();
    logcyc.delete();
    rst = 1'b1;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (logq.size() < n && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk(name, logq.size(), n);
  endtask

  task automatic chk_log(input int k, input int tid, input bit first, input int data, input string name);
    chk($sformatf("%s[%0d]", name, k),
        (k < logq.size()) ? 32'(logq[k]) : 32'hFFFF_FFFF,
        {21'b0, 2'(tid), first, 8'(data)});
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_tvalid"}, 32'(m_tvalid), 0);
    chk({name, "_tfirst"}, 32'(m_tfirst), 0);
    chk({name, "_tdata"},  32'(m_tdata), 0);
    chk({name, "_tid"},    32'(m_tid), 0);
    chk({name, "_tnext"},  32'(s_tnext), 0);
    chk({name, "_err"},    32'(err), 0);
    chk({name, "_fc"},     32'(fc), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d1 [6];
    logic [7:0] d3 [6];
    bit         f3 [6];

    fork
      driver_loop();
      model_update_loop();
      compare_loop();
    join_none

    #1;
    chk_reset_outputs("por");

    // Single channel: ch2 sends two frames.
    reset_begin();
    d1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int k = 0; k < 6; k++) srcq[2].push_back({(k % 3 == 0), d1[k]});
    reset_end();
    wait_log(6, 40, "single_count");
    for (int k = 0; k < 6; k++) chk_log(k, 2, (k % 3 == 0), int'(d1[k]), "single");
    repeat (2) @(negedge clk);
    chk("single_fc", 32'(fc), 2);
    chk("single_err", 32'(err), 0);

    // All four channels request continuously from reset.
    reset_begin();
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < 2; r++)
        for (int j = 0; j < FW; j++) srcq[c].push_back({(j == 0), 8'(c * 16 + r * 4 + j)});
    reset_end();
    wait_log(24, 100, "rr_count");
    for (int f = 0; f < 8; f++)
      for (int j = 0; j < FW; j++)
        chk_log(f * FW + j, f % CH, (j == 0), (f % CH) * 16 + (f / CH) * 4 + j, "rr");
    for (int k = 1; k < 24; k++)
      chk($sformatf("rr_gap[%0d]", k), (k < logcyc.size()) ? logcyc[k] - logcyc[k-1] : -1, 1);

    // Truncated frame on ch1, then a new frame.
    reset_begin();
    d3 = '{8'hA0, 8'hA1, 8'h00, 8'hB0, 8'hB1, 8'hB2};
    f3 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    srcq[1].push_back({1'b1, 8'hA0});
    srcq[1].push_back({1'b0, 8'hA1});
    srcq[1].push_back({1'b1, 8'hB0});
    srcq[1].push_back({1'b0, 8'hB1});
    srcq[1].push_back({1'b0, 8'hB2});
    reset_end();
    wait_log(6, 40, "trunc_count");
    for (int k = 0; k < 6; k++) chk_log(k, 1, f3[k], int'(d3[k]), "trunc");
    chk("trunc_stall", (logcyc.size() > 2) ? logcyc[2] - logcyc[1] : -1, 2);
    chk("trunc_b2b",   (logcyc.size() > 3) ? logcyc[3] - logcyc[2] : -1, 1);
    repeat (2) @(negedge clk);
    chk("trunc_err", 32'(err), 32'h2);
    chk("trunc_fc", 32'(fc), 2);

    // Orphan word on ch3 while idle, then err_clr.
    reset_begin();
    srcq[3].push_back({1'b0, 8'h7F});
    reset_end();
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (s_tvalid[3]) break;
    end
    chk("orphan_offered", 32'(s_tvalid[3]), 1);
    chk("orphan_tnext", 32'(s_tnext), 32'h8);
    chk("orphan_mvalid", 32'(m_tvalid), 0);
    @(negedge clk);
    chk("orphan_err", 32'(err), 32'h8);
    @(posedge clk); #2 err_clr = 1'b1;
    @(posedge clk); #2 err_clr = 1'b0;
    @(negedge clk);
    chk("orphan_err_clr", 32'(err), 0);
    chk("orphan_nolog", logq.size(), 0);

    // Converter backpressure mid-frame.
    reset_begin();
    rdy_mode = 2;
    m_tnext  = 1'b1;
    srcq[0].push_back({1'b1, 8'hC0});
    srcq[0].push_back({1'b0, 8'hC1});
    srcq[0].push_back({1'b0, 8'hC2});
    reset_end();
    wait_log(1, 20, "bp_first");
    @(posedge clk); #2 m_tnext = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_tvalid", 32'(m_tvalid), 1);
      chk("bp_tdata", 32'(m_tdata), 32'hC1);
      chk("bp_tnext", 32'(s_tnext), 0);
    end
    @(posedge clk); #2 m_tnext = 1'b1;
    wait_log(3, 20, "bp_count");
    chk_log(0, 0, 1'b1, 'hC0, "bp");
    chk_log(1, 0, 1'b0, 'hC1, "bp");
    chk_log(2, 0, 1'b0, 'hC2, "bp");
    @(negedge clk);
    chk("bp_fc", 32'(fc), 1);
    rdy_mode = 0;

    // Asynchronous reset in the middle of a ch0 frame.
    reset_begin();
    srcq[2].push_back({1'b0, 8'h55});
    srcq[0].push_back({1'b1, 8'hD0});
    srcq[0].push_back({1'b0, 8'hD1});
    srcq[0].push_back({1'b0, 8'hD2});
    srcq[0].push_back({1'b1, 8'hE0});
    srcq[0].push_back({1'b0, 8'hE1});
    srcq[0].push_back({1'b0, 8'hE2});
    reset_end();
    wait_log(4, 30, "ar_pre");
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset_outputs("async_rst");
    reset_begin();
    for (int j = 0; j < FW; j++) begin
      srcq[0].push_back({(j == 0), 8'(8'hF0 + j)});
      srcq[1].push_back({(j == 0), 8'(8'h90 + j)});
    end
    reset_end();
    wait_log(6, 40, "ar_post");
    chk_log(0, 0, 1'b1, 'hF0, "ar_post");
    chk_log(3, 1, 1'b1, 'h90, "ar_post");

    // Randomized traffic against the model.
    reset_begin();
    auto_fill = 1;
    vld_pct   = 70;
    rdy_mode  = 1;
    reset_end();
    repeat (4000) begin
      @(posedge clk);
      #2 err_clr = ($urandom_range(63) == 0);
    end
    err_clr = 1'b0;
    @(negedge clk);
    chk("random_progress", 32'(logq.size() > 500), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_frame_arbiter.md
# axis_frame_arbiter

Frame-granular round-robin arbiter that shares one width-converter input between CH source streams. Each source delivers fixed-length frames of FRAME_WORDS N-bit words, with tfirst on word 0. The block grants one source per frame and forwards that frame whole to the converter's s_axis port, so the converter never sees interleaved or misaligned frames. Orphan words are discarded and truncated frames are padded to full length, and both events are flagged per channel.

## Interface
- CH, default 4: number of source channels (≥2)
- N, default 8: data width; equals the converter's N
- FRAME_WORDS, default 3: words per frame; set to the converter's LCM/N so frames stay LCM-aligned
- W_CH = $clog2(CH), W_FW = $clog2(FRAME_WORDS+1): derived, not overridable
- clk  in  1  clock; all state on the rising edge
- rst  in  1  reset; asynchronous, active-low
- s_axis_tvalid  in  CH  per-channel word valid
- s_axis_tdata  in  CH*N  channel i occupies [i*N +: N]
- s_axis_tfirst  in  CH  per-channel frame-start marker
- s_axis_tnext  out  CH  per-channel transfer strobe: high in the cycle the word is consumed
- m_axis_tvalid  out  1  to converter s_axis_tvalid
- m_axis_tdata  out  N  to converter s_axis_tdata
- m_axis_tfirst  out  1  to converter s_axis_tfirst
- m_axis_tnext  in  1  converter s_axis_tnext: word accepted this cycle
- m_axis_tid  out  W_CH  channel currently granted
- err_clr  in  1  one-cycle pulse that clears err
- err  out  CH  sticky per channel: orphan word discarded or frame truncated
- frame_count  out  16  frames completed (passed or padded); wraps modulo 2^16

## Operation
- States:
  - IDLE: no grant.
  - PASS: forwarding the granted channel.
  - PAD: emitting filler for a truncated frame.
- Registers: state, grant[W_CH-1:0], rr_last[W_CH-1:0], cnt[W_FW-1:0] (words sent in the current frame), err, frame_count.
- Candidate set: i is a candidate when s_axis_tvalid[i] && s_axis_tfirst[i]. The winner is the first candidate strictly after rr_last, scanning (rr_last+1) mod CH upward.
- Arbitration happens in IDLE, or in the cycle the last word of a frame (cnt==FRAME_WORDS-1) transfers in PASS or PAD.
  - With a winner: grant←winner, rr_last←winner, cnt←0, state←PASS.
  - Without a winner: state←IDLE.
- PASS drive:
  - m_axis_tvalid = s_axis_tvalid[grant].
  - m_axis_tdata and m_axis_tfirst are muxed from the granted channel.
  - s_axis_tnext[grant] = m_axis_tnext.
  - Each transfer increments cnt. The last transfer also increments frame_count and re-arbitrates.
- Mid-frame tfirst: in PASS with cnt≠0, if the granted channel presents tvalid && tfirst, then that cycle m_axis_tvalid=0 and the word is not consumed. Next cycle: state←PAD, err[grant]←1.
- PAD drive: m_axis_tvalid=1, m_axis_tdata=0, m_axis_tfirst=0. No source is consumed. cnt advances on m_axis_tnext until the frame completes, then frame_count increments and the block re-arbitrates.
- Orphan discard: in any state, a channel i≠grant (or any i in IDLE) with tvalid && !tfirst gets s_axis_tnext[i]=1 that cycle (word dropped) and err[i]←1.
- Non-granted channels presenting tfirst are held (tnext=0) until granted.
- err: err_clr clears all bits. A set event in the same cycle wins over the clear.
- m_axis_tid = grant, valid whenever state≠IDLE.

## Timing
- Reset values:
  - state=IDLE, grant=0, rr_last=CH-1 (channel 0 has first priority), cnt=0.
  - err=0, frame_count=0, m_axis_tid=0.
  - m_axis_tvalid=0, m_axis_tfirst=0, m_axis_tdata=0, s_axis_tnext=0.
- Latency from IDLE: the request is seen in cycle t and the first word appears on m_axis in cycle t+1. Back-to-back frames have zero bubble cycles.
- Data and valid paths are combinational from the source through the mux. The s_axis_tnext path is combinational from m_axis_tnext. m_axis_tvalid never depends on m_axis_tnext, so there is no loop.
- Source stall in PASS (tvalid low): m_axis_tvalid low and cnt holds. The grant is held indefinitely, with no timeout.
- Reset asserted mid-frame: the frame is abandoned immediately and all outputs take their reset values. The converter shares rst, so it resets together.

## Structure
- Package axis_arb_pkg holds:
  - state enum state_t {IDLE, PASS, PAD}
  - packed register struct
  - rr_pick function (rotate, priority-encode, un-rotate), reusable by other arbiters
- Single module with a comb process and an async-reset seq process.
- No sub-modules. Top-level integration instantiates this block ahead of the width converter.

## Test plan
- Single channel: ch2 sends 2 frames (0x11,0x22,0x33 / 0x44,0x55,0x66).
  - m_axis carries the 6 words in order, with tfirst on 0x11 and 0x44.
  - m_axis_tid=2 throughout; frame_count=2; err=0.
- All 4 channels request continuously from reset.
  - Grant order is 0,1,2,3,0,…
  - No idle cycle between frames; each frame is 3 contiguous words.
- ch1 sends 0xA0 (tfirst), 0xA1, then 0xB0 with tfirst.
  - Output: A0, A1, then one stall cycle, then one pad word 0x00.
  - err[1]=1; frame_count+1.
  - 0xB0 is forwarded as the next ch1 frame start once ch1 wins arbitration again.
- ch3 presents 0x7F without tfirst while idle.
  - s_axis_tnext[3]=1 the same cycle; nothing appears on m_axis; err[3]=1.
  - err_clr then returns err to 0.
- Converter backpressure: m_axis_tnext held low 5 cycles mid-frame.
  - cnt and data stay stable; no source word is consumed; the frame completes normally afterwards.
- Async reset asserted mid-frame on ch0.
  - All outputs reach their reset values before the next clk edge.
  - After release, ch0 is granted first.
